r2r_4b_wave_gen: RTL and testbench
==================================

# r2r_4b_wave_gen

Waveform sequencer that drives the 4-bit R2R DAC path. It generates sawtooth, triangle, square or a user-loaded 16-sample pattern at a programmable update rate. An external pass-through mode routes pad data straight to the DAC. It sits directly upstream of the R2R ladder: `r2r_out[3:0]` connects bit-for-bit to the ladder inputs `b0`..`b3`, and all control inputs come from the `ui_in`/`uio_in` pads.

## Interface
- `DIV_RESET`, default 99: reset value of the 8-bit divider (100 clocks per sample at the 10 MHz `clk`).
- `clk`  in  1  system clock, 10 MHz nominal.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `ext_data`  in  1  high = pass-through mode; `data` drives `r2r_out`.
- `load_divider`  in  1  strobe; each rising edge loads one divider nibble from `data`.
- `load_pattern`  in  1  strobe; each rising edge writes `data` into the pattern memory.
- `mode`  in  2  waveform select: 00 saw, 01 triangle, 10 square, 11 pattern.
- `data`  in  4  nibble for divider, pattern or pass-through.
- `r2r_out`  out  4  DAC code; bit 0 = LSB.
- `sample_strobe`  out  1  one-cycle pulse on every generated-mode `r2r_out` update.

## Operation
- **Input synchronisation**
  - Every input except `clk` and `n_rst` passes through a 2-flop synchroniser.
  - `load_divider` and `load_pattern` also get a third flop for rising-edge detection.
- **Divider load**
  - Registers: nibble pointer `nib_sel`, low shadow `div_lo[3:0]`, active divider `div[7:0]`.
  - Rising edge with `nib_sel`=0: `div_lo` ← `data`, `nib_sel` ← 1.
  - Rising edge with `nib_sel`=1: `div` ← {`data`, `div_lo`}, `nib_sel` ← 0, prescaler ← 0.
  - `div` only changes as a whole byte; a lone first nibble leaves the rate unchanged.
- **Prescaler `pcnt[7:0]`**
  - If `pcnt` == `div`: `pcnt` ← 0 and assert the internal `tick`. Otherwise `pcnt` increments.
  - Sample period = `div`+1 clocks; `div`=0 gives a tick every clock.
- **Phase `ph[4:0]`**
  - On `tick`: `r2r_out` ← f(`mode`, `ph`), then `ph` ← `ph`+1, wrapping 31→0. `sample_strobe` pulses in the same cycle.
  - f, saw: `ph[3:0]`.
  - f, triangle: `ph[4]` ? ~`ph[3:0]` : `ph[3:0]`. Sequence is 0..15,15..0; period 32 ticks.
  - f, square: `ph[4]` ? 4'hF : 4'h0.
  - f, pattern: `mem[ph[3:0]]`.
- **Mode change:** a new `mode` is used at the next tick; `ph` is not reset.
- **Pattern memory**
  - 16×4 flops plus write pointer `wptr[3:0]`.
  - Each `load_pattern` rising edge: `mem[wptr]` ← `data`, `wptr`+1, wrapping 15→0.
  - Writes are allowed in any mode.
  - A write to the address being read becomes visible at the next tick that reads it.
- **Pass-through** (`ext_data` synced high)
  - `r2r_out` ← synced `data` every clock.
  - `sample_strobe` held 0.
  - Prescaler, phase, divider load and pattern write keep running.
  - When `ext_data` returns low, `r2r_out` holds its last value until the next tick.
- **Simultaneous strobes:** `load_divider` and `load_pattern` edges in the same cycle are both executed.

## Timing
- **Reset values:**
  - `r2r_out`=0, `sample_strobe`=0.
  - `ph`=0, `pcnt`=0, `div`=`DIV_RESET`, `div_lo`=0, `nib_sel`=0, `wptr`=0.
  - All `mem` entries = 0.
  - Synchroniser flops = 0.
- **Reset during operation:** all of the above take effect immediately and asynchronously, with no partial state kept. The first tick comes `div`+1 clocks after `n_rst` deasserts.
- **Strobe latency:** pad rising edge to register update is 3 clocks.
- **Strobe width:** each strobe must be high ≥2 clocks and low ≥2 clocks.
- **`data` hold window:** `data` must be stable from 2 clocks before to 4 clocks after the strobe edge.
- **Pass-through latency:** `data` change to `r2r_out` is 3 clocks.
- **`ext_data` switch latency:** the mode switch takes 2 clocks to take effect.
- **Output glitch freedom:** `r2r_out` is registered, and all 4 bits change on the same `clk` edge.

## Test plan
- **Default rate:** reset release, mode 00, default divider → `sample_strobe` every 100 clocks; `r2r_out` = 0,1,2..15,0,1…
- **Divider load:** `load_divider` with `data`=3, then `data`=0 → strobe period becomes 4 clocks. After only the first nibble (`data`=3), the period stays at 100.
- **Triangle and square:**
  - Mode 01 → 0..15,15,14..0, repeating every 32 strobes.
  - Mode 10 → 16 strobes of 0, then 16 strobes of F.
- **Pattern:**
  - Write A,5,0,F,1..C (16 writes); mode 11 → outputs replay in write order.
  - A 17th write of 7 replaces entry 0 (A → 7) on the next pass.
- **Pass-through:**
  - `ext_data`=1, `data`=9 → `r2r_out`=9 within 3 clocks; `sample_strobe` stays 0.
  - `ext_data`=0 → generated values resume at the next tick.
- **Reset mid-pattern:** `n_rst` low while `r2r_out`=C → `r2r_out`=0 immediately and all `mem` entries read back 0.

Source files
------------

// File: rtl/r2r_4b_wave_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : r2r_4b_wave_gen
// Description : Waveform sequencer for the 4-bit R2R DAC path. It generates
//               sawtooth, triangle, square or a user-loaded 16-sample pattern
//               at a programmable update rate. A pass-through mode routes the
//               synchronised pad nibble straight to the DAC.
// Ports       : clk           - system clock (10 MHz nominal)
//               n_rst         - asynchronous active-low reset
//               ext_data      - high selects pass-through of data
//               load_divider  - strobe, each rising edge loads one divider nibble
//               load_pattern  - strobe, each rising edge writes one pattern entry
//               mode[1:0]     - 00 saw, 01 triangle, 10 square, 11 pattern
//               data[3:0]     - nibble for divider, pattern or pass-through
//               r2r_out[3:0]  - registered DAC code, bit 0 = LSB
//               sample_strobe - one-cycle pulse per generated-mode update
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module r2r_4b_wave_gen #(
    parameter logic [7:0] DIV_RESET = 8'd99
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ext_data,
    input  logic       load_divider,
    input  logic       load_pattern,
    input  logic [1:0] mode,
    input  logic [3:0] data,
    output logic [3:0] r2r_out,
    output logic       sample_strobe
);

    localparam logic [1:0] c_MODE_SAW = 2'b00;
    localparam logic [1:0] c_MODE_TRI = 2'b01;
    localparam logic [1:0] c_MODE_SQR = 2'b10;
    localparam logic [1:0] c_MODE_PAT = 2'b11;

    // Two-flop synchronisers on every pad input; the strobes get a third
    // flop so a rising edge can be detected on fully synchronised levels.
    logic       r_ext_s1, r_ext_s2;
    logic       r_ldd_s1, r_ldd_s2, r_ldd_s3;
    logic       r_ldp_s1, r_ldp_s2, r_ldp_s3;
    logic [1:0] r_mode_s1, r_mode_s2;
    logic [3:0] r_data_s1, r_data_s2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ext_s1  <= 1'b0;
            r_ext_s2  <= 1'b0;
            r_ldd_s1  <= 1'b0;
            r_ldd_s2  <= 1'b0;
            r_ldd_s3  <= 1'b0;
            r_ldp_s1  <= 1'b0;
            r_ldp_s2  <= 1'b0;
            r_ldp_s3  <= 1'b0;
            r_mode_s1 <= 2'b00;
            r_mode_s2 <= 2'b00;
            r_data_s1 <= 4'h0;
            r_data_s2 <= 4'h0;
        end else begin
            r_ext_s1  <= ext_data;
            r_ext_s2  <= r_ext_s1;
            r_ldd_s1  <= load_divider;
            r_ldd_s2  <= r_ldd_s1;
            r_ldd_s3  <= r_ldd_s2;
            r_ldp_s1  <= load_pattern;
            r_ldp_s2  <= r_ldp_s1;
            r_ldp_s3  <= r_ldp_s2;
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
            r_data_s1 <= data;
            r_data_s2 <= r_data_s1;
        end
    end

    logic w_div_edge;
    logic w_pat_edge;
    assign w_div_edge = r_ldd_s2 & ~r_ldd_s3;
    assign w_pat_edge = r_ldp_s2 & ~r_ldp_s3;

    // Divider load and prescaler. The low nibble is held in a shadow register
    // so the active divider only ever changes as a complete byte; completing
    // a load also restarts the prescaler so the new rate starts cleanly.
    logic       r_nib_sel;
    logic [3:0] r_div_lo;
    logic [7:0] r_div;
    logic [7:0] r_pcnt;
    logic       w_tick;

    assign w_tick = (r_pcnt == r_div);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_nib_sel <= 1'b0;
            r_div_lo  <= 4'h0;
            r_div     <= DIV_RESET;
            r_pcnt    <= 8'd0;
        end else begin
            if (w_div_edge) begin
                if (!r_nib_sel) begin
                    r_div_lo  <= r_data_s2;
                    r_nib_sel <= 1'b1;
                end else begin
                    r_div     <= {r_data_s2, r_div_lo};
                    r_nib_sel <= 1'b0;
                end
            end

            if ((w_div_edge && r_nib_sel) || w_tick) begin
                r_pcnt <= 8'd0;
            end else begin
                r_pcnt <= r_pcnt + 8'd1;
            end
        end
    end

    // Pattern memory with an auto-incrementing write pointer.
    logic [3:0] r_mem [16];
    logic [3:0] r_wptr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 4'h0;
            end
            r_wptr <= 4'h0;
        end else if (w_pat_edge) begin
            r_mem[r_wptr] <= r_data_s2;
            r_wptr        <= r_wptr + 4'h1;
        end
    end

    // Waveform lookup from the current phase.
    logic [4:0] r_ph;
    logic [3:0] w_wave;

    always_comb begin
        w_wave = 4'h0;
        case (r_mode_s2)
            c_MODE_SAW: w_wave = r_ph[3:0];
            c_MODE_TRI: w_wave = r_ph[4] ? ~r_ph[3:0] : r_ph[3:0];
            c_MODE_SQR: w_wave = r_ph[4] ? 4'hF : 4'h0;
            c_MODE_PAT: w_wave = r_mem[r_ph[3:0]];
            default:    w_wave = 4'h0;
        endcase
    end

    // Output register. The phase keeps advancing in pass-through so the
    // generated waveform resumes where it would have been.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ph          <= 5'd0;
            r2r_out       <= 4'h0;
            sample_strobe <= 1'b0;
        end else begin
            if (w_tick) begin
                r_ph <= r_ph + 5'd1;
            end

            if (r_ext_s2) begin
                r2r_out       <= r_data_s2;
                sample_strobe <= 1'b0;
            end else if (w_tick) begin
                r2r_out       <= w_wave;
                sample_strobe <= 1'b1;
            end else begin
                sample_strobe <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_r2r_4b_wave_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_r2r_4b_wave_gen
// Description : Scoreboard bench for r2r_4b_wave_gen. A reference model
//               schedules each generated sample by arithmetic on edge numbers
//               and pushes the expected code and edge into a queue; a monitor
//               pops and compares whenever sample_strobe is seen.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_r2r_4b_wave_gen;

    localparam int c_DIV_RESET = 99;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       ext_data = 1'b0;
    logic       load_divider = 1'b0;
    logic       load_pattern = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] data = 4'h0;
    logic [3:0] r2r_out;
    logic       sample_strobe;

    int checks = 0;
    int failures = 0;

    r2r_4b_wave_gen #(.DIV_RESET(8'(c_DIV_RESET))) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .ext_data     (ext_data),
        .load_divider (load_divider),
        .load_pattern (load_pattern),
        .mode         (mode),
        .data         (data),
        .r2r_out      (r2r_out),
        .sample_strobe(sample_strobe)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        int         c;
    } exp_t;

    typedef struct {
        logic       ext;
        logic       ldd;
        logic       ldp;
        logic [1:0] md;
        logic [3:0] dat;
    } pad_t;

    exp_t q[$];

    // ---------------- reference model ----------------
    int         cyc = 0;
    int         m_ph, m_div, m_lo, m_nib, m_wptr, m_next;
    logic [3:0] m_mem [16];
    pad_t       h1, h2, h3, eff, prv, now_p;

    function automatic pad_t zero_pad();
        pad_t p;
        p.ext = 1'b0; p.ldd = 1'b0; p.ldp = 1'b0; p.md = 2'b00; p.dat = 4'h0;
        return p;
    endfunction

    always @(posedge clk) begin
        logic [3:0] v;
        cyc++;
        if (!n_rst) begin
            m_ph = 0; m_div = c_DIV_RESET; m_lo = 0; m_nib = 0; m_wptr = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
            m_next = cyc + m_div + 1;
            h1 = zero_pad(); h2 = zero_pad(); h3 = zero_pad();
            q.delete();
        end else begin
            // pads take effect two edges after they are sampled
            eff = h2;
            prv = h3;
            if (cyc == m_next) begin
                case (eff.md)
                    2'b00:   v = 4'(m_ph % 16);
                    2'b01:   v = (m_ph < 16) ? 4'(m_ph) : 4'(31 - m_ph);
                    2'b10:   v = (m_ph < 16) ? 4'h0 : 4'hF;
                    default: v = m_mem[m_ph % 16];
                endcase
                if (!eff.ext) q.push_back('{v: v, c: cyc});
                m_ph   = (m_ph + 1) % 32;
                m_next = cyc + m_div + 1;
            end
            if (eff.ldd && !prv.ldd) begin
                if (m_nib == 0) begin
                    m_lo  = int'(eff.dat);
                    m_nib = 1;
                end else begin
                    m_div  = int'(eff.dat) * 16 + m_lo;
                    m_nib  = 0;
                    m_next = cyc + m_div + 1;
                end
            end
            if (eff.ldp && !prv.ldp) begin
                m_mem[m_wptr] = eff.dat;
                m_wptr = (m_wptr + 1) % 16;
            end
            now_p.ext = ext_data; now_p.ldd = load_divider; now_p.ldp = load_pattern;
            now_p.md = mode; now_p.dat = data;
            h3 = h2; h2 = h1; h1 = now_p;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (n_rst) begin
            while (q.size() > 0 && q[0].c < cyc) begin
                checks++; failures++;
                $display("FAIL missed_strobe: no strobe at edge %0d, required code %h", q[0].c, q[0].v);
                void'(q.pop_front());
            end
            if (sample_strobe) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: edge %0d code %h, required no strobe", cyc, r2r_out);
                end else if (q[0].c != cyc) begin
                    failures++;
                    $display("FAIL early_strobe: edge %0d, required edge %0d", cyc, q[0].c);
                end else begin
                    if (r2r_out !== q[0].v) begin
                        failures++;
                        $display("FAIL sample_code: edge %0d got %h required %h", cyc, r2r_out, q[0].v);
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic pulse_div(input logic [3:0] d);
        data = d;
        wait_cycles(2);
        load_divider = 1'b1;
        wait_cycles(3);
        load_divider = 1'b0;
        wait_cycles(3);
    endtask

    task automatic pulse_pat(input logic [3:0] d);
        data = d;
        wait_cycles(2);
        load_pattern = 1'b1;
        wait_cycles(3);
        load_pattern = 1'b0;
        wait_cycles(3);
    endtask

    logic [3:0] pat_list [16];

    initial begin
        bit found;
        logic [3:0] d;
        pat_list = '{4'hA, 4'h5, 4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4,
                     4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

        // reset state
        wait_cycles(3);
        check_val("reset_r2r_out", r2r_out, 4'h0);
        check_val("reset_strobe", {3'b0, sample_strobe}, 4'h0);
        n_rst = 1'b1;

        // default rate, sawtooth
        wait_cycles(20 * 100 + 10);

        // first nibble alone leaves rate at 100, second completes div=3
        pulse_div(4'h3);
        wait_cycles(300);
        pulse_div(4'h0);
        wait_cycles(160);

        // triangle and square
        mode = 2'b01;
        wait_cycles(280);
        mode = 2'b10;
        wait_cycles(280);

        // pattern load then replay, then 17th write overwrites entry 0
        for (int i = 0; i < 16; i++) pulse_pat(pat_list[i]);
        mode = 2'b11;
        wait_cycles(160);
        pulse_pat(4'h7);
        wait_cycles(160);

        // randomised modes, dividers and pattern writes
        for (int it = 0; it < 6; it++) begin
            mode = 2'($urandom_range(0, 3));
            pulse_div(4'($urandom_range(0, 15)));
            pulse_div(4'h0);
            for (int k = 0; k < 3; k++) pulse_pat(4'($urandom));
            wait_cycles(150 + $urandom_range(0, 50));
        end

        // pass-through: data reaches output within 3 clocks, no strobes
        mode = 2'b00;
        ext_data = 1'b1;
        data = 4'h9;
        wait_cycles(3);
        check_val("pass_through_9", r2r_out, 4'h9);
        for (int k = 0; k < 5; k++) begin
            d = 4'($urandom);
            data = d;
            wait_cycles(3);
            check_val("pass_through_rand", r2r_out, d);
        end
        pulse_div(4'h2);
        pulse_div(4'h0);
        ext_data = 1'b0;
        wait_cycles(120);

        // reset in the middle of a pattern while the output is C
        pulse_div(4'h3);
        pulse_div(4'h0);
        mode = 2'b11;
        for (int i = 0; i < 16; i++) pulse_pat(pat_list[i]);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (sample_strobe && r2r_out == 4'hC) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_for_C: got no C sample within 400 clocks, required one");
        end
        #2 n_rst = 1'b0;
        #1;
        check_val("async_reset_r2r_out", r2r_out, 4'h0);
        check_val("async_reset_strobe", {3'b0, sample_strobe}, 4'h0);
        wait_cycles(3);
        n_rst = 1'b1;
        // memory reads back zero at default rate, then write pointer restarts at 0
        wait_cycles(2200);
        pulse_pat(4'h5);
        pulse_div(4'h1);
        pulse_div(4'h0);
        wait_cycles(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
